// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns PS/2 scan code set 2 byte streams into key events (code, extended,
// break, optional ASCII) and queues them in a small FIFO for the consumer.
// Build option: define PS2_KEY_ASCII_EN to compile in the ASCII map and the
// per-entry ASCII storage; without it key_ascii is tied to 0x00.
//
// state      | meaning
// -----------+---------------------------------------------
// ST_IDLE    | no prefix pending
// ST_EXT     | E0 seen, waiting for the key byte
// ST_BRK     | F0 seen, waiting for the key byte
// ST_EXT_BRK | both E0 and F0 seen, waiting for the key byte

module ps2_key_decoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_rdy,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic [7:0] key_ascii,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       shift_held,
    output logic       overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t state_q, state_d;

    logic          emit;
    logic          ev_ext;
    logic          ev_brk;
    logic          is_discard;

    logic          shift_l_q, shift_l_d;
    logic          shift_r_q, shift_r_d;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          fifo_full;
    logic          pop;
    logic          push_ok;

    logic [7:0]    code_mem_q [FIFO_DEPTH];
    logic          ext_mem_q  [FIFO_DEPTH];
    logic          brk_mem_q  [FIFO_DEPTH];

`ifdef PS2_KEY_ASCII_EN
    logic [7:0]    ascii_mem_q [FIFO_DEPTH];
    logic [7:0]    ev_ascii;

    // Scan code set 2 to ASCII; letters are upper-cased when 'upper' is set.
    function automatic logic [7:0] ascii_map(input logic [7:0] code, input logic upper);
        logic [7:0] ch;
        ch = 8'h00;
        case (code)
            8'h1C: ch = 8'h61; 8'h32: ch = 8'h62; 8'h21: ch = 8'h63; 8'h23: ch = 8'h64;
            8'h24: ch = 8'h65; 8'h2B: ch = 8'h66; 8'h34: ch = 8'h67; 8'h33: ch = 8'h68;
            8'h43: ch = 8'h69; 8'h3B: ch = 8'h6A; 8'h42: ch = 8'h6B; 8'h4B: ch = 8'h6C;
            8'h3A: ch = 8'h6D; 8'h31: ch = 8'h6E; 8'h44: ch = 8'h6F; 8'h4D: ch = 8'h70;
            8'h15: ch = 8'h71; 8'h2D: ch = 8'h72; 8'h1B: ch = 8'h73; 8'h2C: ch = 8'h74;
            8'h3C: ch = 8'h75; 8'h2A: ch = 8'h76; 8'h1D: ch = 8'h77; 8'h22: ch = 8'h78;
            8'h35: ch = 8'h79; 8'h1A: ch = 8'h7A;
            8'h45: ch = 8'h30; 8'h16: ch = 8'h31; 8'h1E: ch = 8'h32; 8'h26: ch = 8'h33;
            8'h25: ch = 8'h34; 8'h2E: ch = 8'h35; 8'h36: ch = 8'h36; 8'h3D: ch = 8'h37;
            8'h3E: ch = 8'h38; 8'h46: ch = 8'h39;
            8'h29: ch = 8'h20;
            8'h5A: ch = 8'h0D;
            8'h66: ch = 8'h08;
            default: ch = 8'h00;
        endcase
        if (upper && (ch >= 8'h61) && (ch <= 8'h7A)) begin
            ch = ch - 8'h20;
        end
        return ch;
    endfunction

    // Extended keys never map; shift level is the one before this byte's own update.
    always_comb begin
        ev_ascii = 8'h00;
        if (!ev_ext) begin
            ev_ascii = ascii_map(in_data, shift_l_q | shift_r_q);
        end
    end
`endif

    assign is_discard = in_data inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA,
                                        8'hFC, 8'hFD, 8'hFE, 8'hFF};

    // Prefix tracking: decides the next state and whether this byte emits an event.
    always_comb begin
        state_d = state_q;
        emit    = 1'b0;
        ev_ext  = 1'b0;
        ev_brk  = 1'b0;
        if (in_rdy) begin
            if (is_discard) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (in_data == 8'hE0) begin
                            state_d = ST_EXT;
                        end else if (in_data == 8'hF0) begin
                            state_d = ST_BRK;
                        end else begin
                            emit = 1'b1;
                        end
                    end
                    ST_EXT: begin
                        if (in_data == 8'hE0) begin
                            state_d = ST_EXT;
                        end else if (in_data == 8'hF0) begin
                            state_d = ST_EXT_BRK;
                        end else begin
                            emit    = 1'b1;
                            ev_ext  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_BRK: begin
                        if (in_data == 8'hF0) begin
                            state_d = ST_BRK;
                        end else if (in_data == 8'hE0) begin
                            state_d = ST_EXT_BRK;
                        end else begin
                            emit    = 1'b1;
                            ev_brk  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    ST_EXT_BRK: begin
                        if ((in_data == 8'hE0) || (in_data == 8'hF0)) begin
                            state_d = ST_EXT_BRK;
                        end else begin
                            emit    = 1'b1;
                            ev_ext  = 1'b1;
                            ev_brk  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Prefix state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Shift flags follow non-extended 0x12/0x59 make/break regardless of FIFO space.
    always_comb begin
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        if (emit && !ev_ext) begin
            if (in_data == 8'h12) begin
                shift_l_d = !ev_brk;
            end
            if (in_data == 8'h59) begin
                shift_r_d = !ev_brk;
            end
        end
    end

    // Shift flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_l_q <= 1'b0;
            shift_r_q <= 1'b0;
        end else begin
            shift_l_q <= shift_l_d;
            shift_r_q <= shift_r_d;
        end
    end

    assign fifo_full = (count_q == DEPTH_C);
    assign key_valid = (count_q != '0);
    assign pop       = key_valid && key_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok   = emit && (!fifo_full || pop);

    // FIFO pointer, count and sticky overflow next-state.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (emit && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Event storage; cleared on reset so the head fields read as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                code_mem_q[i]  <= 8'h00;
                ext_mem_q[i]   <= 1'b0;
                brk_mem_q[i]   <= 1'b0;
`ifdef PS2_KEY_ASCII_EN
                ascii_mem_q[i] <= 8'h00;
`endif
            end
        end else if (push_ok) begin
            code_mem_q[wr_ptr_q]  <= in_data;
            ext_mem_q[wr_ptr_q]   <= ev_ext;
            brk_mem_q[wr_ptr_q]   <= ev_brk;
`ifdef PS2_KEY_ASCII_EN
            ascii_mem_q[wr_ptr_q] <= ev_ascii;
`endif
        end
    end

    assign key_code   = code_mem_q[rd_ptr_q];
    assign key_ext    = ext_mem_q[rd_ptr_q];
    assign key_break  = brk_mem_q[rd_ptr_q];
`ifdef PS2_KEY_ASCII_EN
    assign key_ascii  = ascii_mem_q[rd_ptr_q];
`else
    assign key_ascii  = 8'h00;
`endif
    assign shift_held = shift_l_q | shift_r_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Testbench for ps2_key_decoder: directed scenarios plus a randomized run
// checked against an event-level model (prefix flags, shift flags, event queue).

module tb_ps2_key_decoder;

    localparam int DEPTH = 4;
`ifdef PS2_KEY_ASCII_EN
    localparam bit ASC_EN = 1'b1;
`else
    localparam bit ASC_EN = 1'b0;
`endif
    localparam logic [7:0] A_LO = ASC_EN ? 8'h61 : 8'h00;
    localparam logic [7:0] A_UP = ASC_EN ? 8'h41 : 8'h00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_rdy = 1'b0;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic [7:0] key_ascii;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic       shift_held;
    logic       overflow;

    always #5 clk = ~clk;

    ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_rdy(in_rdy),
        .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
        .key_ascii(key_ascii), .key_valid(key_valid), .key_ready(key_ready),
        .shift_held(shift_held), .overflow(overflow)
    );

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
    } ev_t;

    ev_t        exp_q[$];
    logic       m_ext, m_brk, m_shl, m_shr, m_ovf;
    logic [7:0] lc_tab [256];
    int         checks = 0;
    int         errors = 0;

    task automatic init_tab();
        logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                     8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                     8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                     8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
        logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                    8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 256; i++) lc_tab[i] = 8'h00;
        for (int i = 0; i < 26; i++) lc_tab[letters[i]] = 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) lc_tab[digits[i]] = 8'h30 + 8'(i);
        lc_tab[8'h29] = 8'h20;
        lc_tab[8'h5A] = 8'h0D;
        lc_tab[8'h66] = 8'h08;
    endtask

    function automatic logic [7:0] exp_ascii(input logic [7:0] code, input logic ext,
                                             input logic shift);
        logic [7:0] a;
        if (!ASC_EN || ext) return 8'h00;
        a = lc_tab[code];
        if (shift && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
        return a;
    endfunction

    function automatic logic is_discard(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hAA) || (b == 8'hE1) || (b == 8'hEE) ||
               (b == 8'hFA) || (b >= 8'hFC);
    endfunction

    // Drives one clock cycle of inputs from a falling edge, updates the model,
    // and returns at the next falling edge with outputs settled.
    task automatic step(input logic r, input logic v, input logic [7:0] d, input logic k);
        logic pop;
        ev_t  e;
        rst = r; in_rdy = v; in_data = d; key_ready = k;
        if (r) begin
            exp_q.delete();
            m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_ovf = 0;
        end else begin
            pop = k && (exp_q.size() != 0);
            if (pop) void'(exp_q.pop_front());
            if (v) begin
                if (is_discard(d)) begin
                    m_ext = 0; m_brk = 0;
                end else if (d == 8'hE0) begin
                    m_ext = 1;
                end else if (d == 8'hF0) begin
                    m_brk = 1;
                end else begin
                    e.code = d; e.ext = m_ext; e.brk = m_brk;
                    e.ascii = exp_ascii(d, m_ext, m_shl | m_shr);
                    if (!m_ext && d == 8'h12) m_shl = !m_brk;
                    if (!m_ext && d == 8'h59) m_shr = !m_brk;
                    if (exp_q.size() < DEPTH) exp_q.push_back(e);
                    else m_ovf = 1;
                    m_ext = 0; m_brk = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst = 0; in_rdy = 0; key_ready = 0;
    endtask

    task automatic test_reset();
        step(1, 0, 8'h00, 0);
        step(1, 0, 8'h00, 0);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", key_valid); end
        checks++; if ({key_code, key_ext, key_break, key_ascii} !== 18'h0) begin
            errors++; $display("FAIL reset_head got %h/%b/%b/%h exp all zero", key_code, key_ext, key_break, key_ascii); end
        checks++; if ({shift_held, overflow} !== 2'b00) begin
            errors++; $display("FAIL reset_flags got shift=%b ovf=%b exp 0/0", shift_held, overflow); end
    endtask

    task automatic test_make();
        step(0, 1, 8'h1C, 0);
        checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL make_valid got %b exp 1", key_valid); end
        checks++; if ({key_code, key_ext, key_break, key_ascii} !== {8'h1C, 1'b0, 1'b0, A_LO}) begin
            errors++; $display("FAIL make_head got %h/%b/%b/%h exp 1c/0/0/%h", key_code, key_ext, key_break, key_ascii, A_LO); end
        step(0, 0, 8'h00, 1);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL make_pop got %b exp 0", key_valid); end
    endtask

    task automatic test_break();
        step(0, 1, 8'hF0, 0);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL f0_alone got valid %b exp 0", key_valid); end
        step(0, 1, 8'h1C, 0);
        checks++; if ({key_valid, key_code, key_ext, key_break, key_ascii} !== {1'b1, 8'h1C, 1'b0, 1'b1, A_LO}) begin
            errors++; $display("FAIL break_head got %b/%h/%b/%b/%h exp 1/1c/0/1/%h", key_valid, key_code, key_ext, key_break, key_ascii, A_LO); end
        step(0, 0, 8'h00, 1);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL break_single got valid %b exp 0", key_valid); end
    endtask

    task automatic test_shift();
        logic [7:0] codes [4] = '{8'h12, 8'h1C, 8'h12, 8'h1C};
        logic       brks  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [7:0] ascs  [4] = '{8'h00, A_UP, 8'h00, A_LO};
        step(0, 1, 8'h12, 0);
        step(0, 1, 8'h1C, 0);
        checks++; if (shift_held !== 1'b1) begin errors++; $display("FAIL shift_held_on got %b exp 1", shift_held); end
        step(0, 1, 8'hF0, 0);
        step(0, 1, 8'h12, 0);
        step(0, 1, 8'h1C, 0);
        checks++; if (shift_held !== 1'b0) begin errors++; $display("FAIL shift_held_off got %b exp 0", shift_held); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({key_valid, key_code, key_ext, key_break, key_ascii} !== {1'b1, codes[i], 1'b0, brks[i], ascs[i]}) begin
                errors++; $display("FAIL shift_ev%0d got %b/%h/%b/%b/%h exp 1/%h/0/%b/%h", i, key_valid, key_code, key_ext, key_break, key_ascii, codes[i], brks[i], ascs[i]); end
            step(0, 0, 8'h00, 1);
        end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL shift_drain got valid %b exp 0", key_valid); end
    endtask

    task automatic test_ext();
        step(0, 1, 8'hE0, 0);
        step(0, 1, 8'hF0, 0);
        step(0, 1, 8'h75, 0);
        checks++; if ({key_valid, key_code, key_ext, key_break, key_ascii} !== {1'b1, 8'h75, 1'b1, 1'b1, 8'h00}) begin
            errors++; $display("FAIL ext_brk got %b/%h/%b/%b/%h exp 1/75/1/1/00", key_valid, key_code, key_ext, key_break, key_ascii); end
        step(0, 0, 8'h00, 1);
        step(0, 1, 8'hE0, 0);
        step(0, 1, 8'hFA, 0);
        step(0, 1, 8'h1C, 0);
        checks++; if ({key_valid, key_code, key_ext, key_break} !== {1'b1, 8'h1C, 1'b0, 1'b0}) begin
            errors++; $display("FAIL discard_head got %b/%h/%b/%b exp 1/1c/0/0", key_valid, key_code, key_ext, key_break); end
        step(0, 0, 8'h00, 1);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL discard_count got valid %b exp 0", key_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] pushes [5] = '{8'h1C, 8'h32, 8'h15, 8'h1A, 8'h16};
        logic [7:0] order  [4] = '{8'h32, 8'h15, 8'h1A, 8'h45};
        step(1, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 1, pushes[i], 0);
        checks++; if ({overflow, key_valid, key_code} !== {1'b1, 1'b1, 8'h1C}) begin
            errors++; $display("FAIL ovf_set got ovf=%b valid=%b code=%h exp 1/1/1c", overflow, key_valid, key_code); end
        step(0, 1, 8'h45, 1);
        checks++; if ({overflow, key_code} !== {1'b1, 8'h32}) begin
            errors++; $display("FAIL ovf_poppush got ovf=%b code=%h exp 1/32", overflow, key_code); end
        for (int i = 0; i < 4; i++) begin
            checks++; if ({key_valid, key_code} !== {1'b1, order[i]}) begin
                errors++; $display("FAIL ovf_order%0d got %b/%h exp 1/%h", i, key_valid, key_code, order[i]); end
            step(0, 0, 8'h00, 1);
        end
        checks++; if ({key_valid, overflow} !== 2'b01) begin
            errors++; $display("FAIL ovf_drain got valid=%b ovf=%b exp 0/1", key_valid, overflow); end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 8'h1C, 0);
        step(0, 1, 8'hF0, 0);
        step(1, 0, 8'h00, 0);
        checks++; if ({key_valid, overflow, shift_held, key_code, key_ext, key_break, key_ascii} !== 21'h0) begin
            errors++; $display("FAIL rstmid_outputs got v=%b o=%b s=%b %h/%b/%b/%h exp all zero", key_valid, overflow, shift_held, key_code, key_ext, key_break, key_ascii); end
        step(0, 1, 8'h1C, 0);
        checks++; if ({key_valid, key_code, key_break} !== {1'b1, 8'h1C, 1'b0}) begin
            errors++; $display("FAIL rstmid_make got %b/%h/%b exp 1/1c/0", key_valid, key_code, key_break); end
        step(0, 0, 8'h00, 1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] pool [12] = '{8'h1C, 8'h32, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66,
                                  8'h21, 8'h75, 8'h1A, 8'h3E, 8'h0E};
        logic [7:0] b;
        logic       v, k;
        int         r;
        step(1, 0, 8'h00, 0);
        for (int n = 0; n < 800; n++) begin
            v = ($urandom_range(0, 9) < 8);
            k = $urandom_range(0, 1);
            r = $urandom_range(0, 99);
            if (r < 25)      b = ($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0;
            else if (r < 33) b = ($urandom_range(0, 1) != 0) ? 8'hFA : 8'hAA;
            else if (r < 45) b = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
            else if (r < 88) b = pool[$urandom_range(0, 11)];
            else             b = 8'($urandom_range(0, 255));
            step(0, v, b, k);
            checks++; if (key_valid !== (exp_q.size() != 0)) begin
                errors++; $display("FAIL rand_valid cycle %0d got %b exp %b", n, key_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                checks++; if ({key_code, key_ext, key_break, key_ascii} !== {exp_q[0].code, exp_q[0].ext, exp_q[0].brk, exp_q[0].ascii}) begin
                    errors++; $display("FAIL rand_head cycle %0d got %h/%b/%b/%h exp %h/%b/%b/%h", n, key_code, key_ext, key_break, key_ascii,
                                       exp_q[0].code, exp_q[0].ext, exp_q[0].brk, exp_q[0].ascii); end
            end
            checks++; if ({shift_held, overflow} !== {m_shl | m_shr, m_ovf}) begin
                errors++; $display("FAIL rand_flags cycle %0d got %b/%b exp %b/%b", n, shift_held, overflow, m_shl | m_shr, m_ovf); end
        end
    endtask

    initial begin
        m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_ovf = 0;
        init_tab();
        @(negedge clk);
        test_reset();
        test_make();
        test_break();
        test_shift();
        test_ext();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
